// File: rtl/inst_cache_pkg.sv
// Shared constants and address-slicing macros for the direct-mapped instruction cache.
// The optional ICACHE_STATS_EN build adds hit/miss counters in inst_cache.
`ifndef INST_CACHE_PKG_MACROS
`define INST_CACHE_PKG_MACROS
`define ICACHE_INDEX(addr, iw) addr[(iw)+1:2]
`define ICACHE_TAG(addr, aw, iw) addr[(aw)-1:(iw)+2]
`endif

package inst_cache_pkg;
  localparam int unsigned ICACHE_INDEX_WIDTH = 8;
  localparam logic [0:0]  ICACHE_IDLE = 1'b0;
  localparam logic [0:0]  ICACHE_MISS = 1'b1;
endpackage

// File: rtl/inst_cache_array.sv
// Valid/tag/data storage for inst_cache: one combinational read port, one synchronous write port.
module inst_cache_array
  import inst_cache_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int unsigned TAG_WIDTH   = 22
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] i_rd_index,
  output logic                   o_rd_valid,
  output logic [TAG_WIDTH-1:0]   o_rd_tag,
  output logic [31:0]            o_rd_data,
  input  logic                   i_we,
  input  logic [INDEX_WIDTH-1:0] i_wr_index,
  input  logic [TAG_WIDTH-1:0]   i_wr_tag,
  input  logic [31:0]            i_wr_data
);
  localparam int unsigned DEPTH = 1 << INDEX_WIDTH;

  logic [DEPTH-1:0]     r_valid;
  logic [TAG_WIDTH-1:0] r_tag  [DEPTH];
  logic [31:0]          r_data [DEPTH];

  // Only valid bits need reset; tag/data are qualified by valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[i_rd_index];
endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache between the fetcher and mem_ctrl; control FSM and output registers.
// Optional macro ICACHE_STATS_EN adds saturating stat_hit/stat_miss counters.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  jump_wrong_flag,
  input  logic                  IF_req,
  input  logic [ADDR_WIDTH-1:0] IF_addr,
  output logic                  IF_flag,
  output logic [31:0]           IF_inst,
  output logic                  MC_req,
  output logic [ADDR_WIDTH-1:0] MC_addr,
  input  logic                  MC_flag,
  input  logic [31:0]           MC_inst
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           stat_hit,
  output logic [31:0]           stat_miss
`endif
);
  localparam int unsigned TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

  logic [0:0]            r_state;
  logic                  r_if_flag;
  logic [31:0]           r_if_inst;
  logic                  r_mc_req;
  logic [ADDR_WIDTH-1:0] r_mc_addr;

  logic                  w_rd_valid;
  logic [TAG_WIDTH-1:0]  w_rd_tag;
  logic [31:0]           w_rd_data;
  logic                  w_hit;
  logic                  w_take;
  logic                  w_we;
  logic                  w_unused_addr_bits;

  assign w_unused_addr_bits = ^IF_addr[1:0];

  assign w_hit  = w_rd_valid && (w_rd_tag == `ICACHE_TAG(IF_addr, ADDR_WIDTH, INDEX_WIDTH));
  assign w_take = rdy && !jump_wrong_flag && IF_req && (r_state == ICACHE_IDLE);
  // A fill during a flush still lands in the array; only the IF response is dropped.
  assign w_we   = rdy && (r_state == ICACHE_MISS) && MC_flag;

  inst_cache_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .i_rd_index (`ICACHE_INDEX(IF_addr, INDEX_WIDTH)),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_we       (w_we),
    .i_wr_index (`ICACHE_INDEX(r_mc_addr, INDEX_WIDTH)),
    .i_wr_tag   (`ICACHE_TAG(r_mc_addr, ADDR_WIDTH, INDEX_WIDTH)),
    .i_wr_data  (MC_inst)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ICACHE_IDLE;
      r_if_flag <= 1'b0;
      r_if_inst <= '0;
      r_mc_req  <= 1'b0;
      r_mc_addr <= '0;
    end else if (rdy) begin
      r_if_flag <= 1'b0;
      if (jump_wrong_flag) begin
        r_mc_req <= 1'b0;
        r_state  <= ICACHE_IDLE;
      end else begin
        case (r_state)
          ICACHE_IDLE: begin
            if (w_take) begin
              if (w_hit) begin
                r_if_flag <= 1'b1;
                r_if_inst <= w_rd_data;
              end else begin
                r_mc_req  <= 1'b1;
                r_mc_addr <= IF_addr;
                r_state   <= ICACHE_MISS;
              end
            end
          end
          ICACHE_MISS: begin
            if (MC_flag) begin
              r_mc_req  <= 1'b0;
              r_if_flag <= 1'b1;
              r_if_inst <= MC_inst;
              r_state   <= ICACHE_IDLE;
            end
          end
          default: r_state <= ICACHE_IDLE;
        endcase
      end
    end
  end

  assign IF_flag = r_if_flag;
  assign IF_inst = r_if_inst;
  assign MC_req  = r_mc_req;
  assign MC_addr = r_mc_addr;

`ifdef ICACHE_STATS_EN
  logic [31:0] r_stat_hit;
  logic [31:0] r_stat_miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_hit  <= '0;
      r_stat_miss <= '0;
    end else begin
      if (w_take && w_hit && (r_stat_hit != '1)) begin
        r_stat_hit <= r_stat_hit + 32'd1;
      end
      if (w_take && !w_hit && (r_stat_miss != '1)) begin
        r_stat_miss <= r_stat_miss + 32'd1;
      end
    end
  end

  assign stat_hit  = r_stat_hit;
  assign stat_miss = r_stat_miss;
`endif
endmodule

// File: tb/tb_inst_cache.sv
// Directed self-checking bench for inst_cache; the bench itself plays mem_ctrl.
module tb_inst_cache;
  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        jump_wrong_flag;
  logic        IF_req;
  logic [31:0] IF_addr;
  logic        IF_flag;
  logic [31:0] IF_inst;
  logic        MC_req;
  logic [31:0] MC_addr;
  logic        MC_flag;
  logic [31:0] MC_inst;
`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hit;
  logic [31:0] stat_miss;
`endif

  int checks = 0;
  int failures = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  inst_cache #(.INDEX_WIDTH(8), .ADDR_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .jump_wrong_flag (jump_wrong_flag),
    .IF_req          (IF_req),
    .IF_addr         (IF_addr),
    .IF_flag         (IF_flag),
    .IF_inst         (IF_inst),
    .MC_req          (MC_req),
    .MC_addr         (MC_addr),
    .MC_flag         (MC_flag),
    .MC_inst         (MC_inst)
`ifdef ICACHE_STATS_EN
    ,
    .stat_hit        (stat_hit),
    .stat_miss       (stat_miss)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task fetch(input logic [31:0] a);
    IF_req  = 1'b1;
    IF_addr = a;
    tick();
    IF_req  = 1'b0;
  endtask

  task mc_return(input logic [31:0] d, input int unsigned wait_cycles);
    repeat (wait_cycles) tick();
    MC_flag = 1'b1;
    MC_inst = d;
    tick();
    MC_flag = 1'b0;
  endtask

  task test_reset;
    rst = 1'b1; rdy = 1'b1; jump_wrong_flag = 1'b0; IF_req = 1'b0;
    IF_addr = '0; MC_flag = 1'b0; MC_inst = '0;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (IF_flag !== 1'b0) begin failures++; $display("FAIL reset_if_flag: got %0h expected 0", IF_flag); end
    checks++; if (IF_inst !== 32'h0) begin failures++; $display("FAIL reset_if_inst: got %h expected 0", IF_inst); end
    checks++; if (MC_req !== 1'b0) begin failures++; $display("FAIL reset_mc_req: got %0h expected 0", MC_req); end
    checks++; if (MC_addr !== 32'h0) begin failures++; $display("FAIL reset_mc_addr: got %h expected 0", MC_addr); end
    tick();
  endtask

  task test_cold_miss;
    fetch(32'h0000_0000);
    exp_misses++;
    checks++; if (MC_req !== 1'b1) begin failures++; $display("FAIL cold_mc_req: got %0h expected 1", MC_req); end
    checks++; if (MC_addr !== 32'h0) begin failures++; $display("FAIL cold_mc_addr: got %h expected 0", MC_addr); end
    checks++; if (IF_flag !== 1'b0) begin failures++; $display("FAIL cold_if_flag_early: got %0h expected 0", IF_flag); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (MC_req !== 1'b1 || IF_flag !== 1'b0) begin
        failures++; $display("FAIL cold_hold: got req=%0h flag=%0h expected req=1 flag=0", MC_req, IF_flag);
      end
    end
    mc_return(32'h0000_0513, 0);
    checks++; if (IF_flag !== 1'b1) begin failures++; $display("FAIL cold_if_flag: got %0h expected 1", IF_flag); end
    checks++; if (IF_inst !== 32'h0000_0513) begin failures++; $display("FAIL cold_if_inst: got %h expected 00000513", IF_inst); end
    checks++; if (MC_req !== 1'b0) begin failures++; $display("FAIL cold_mc_req_drop: got %0h expected 0", MC_req); end
    tick();
    checks++; if (IF_flag !== 1'b0) begin failures++; $display("FAIL cold_pulse: got %0h expected 0", IF_flag); end
  endtask

  task test_hit;
    fetch(32'h0000_0000);
    exp_hits++;
    checks++; if (IF_flag !== 1'b1 || IF_inst !== 32'h0000_0513) begin
      failures++; $display("FAIL hit: got flag=%0h inst=%h expected flag=1 inst=00000513", IF_flag, IF_inst);
    end
    checks++; if (MC_req !== 1'b0) begin failures++; $display("FAIL hit_mc_req: got %0h expected 0", MC_req); end
    tick();
    checks++; if (IF_flag !== 1'b0) begin failures++; $display("FAIL hit_pulse: got %0h expected 0", IF_flag); end
  endtask

  task test_conflict;
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    addrs = '{32'h0000_0004, 32'h0000_0404, 32'h0000_0004};
    datas = '{32'h0000_1111, 32'h0000_2222, 32'h0000_1111};
    for (int i = 0; i < 3; i++) begin
      fetch(addrs[i]);
      exp_misses++;
      checks++; if (MC_req !== 1'b1 || MC_addr !== addrs[i]) begin
        failures++; $display("FAIL conflict_miss%0d: got req=%0h addr=%h expected req=1 addr=%h", i, MC_req, MC_addr, addrs[i]);
      end
      mc_return(datas[i], 2);
      checks++; if (IF_flag !== 1'b1 || IF_inst !== datas[i]) begin
        failures++; $display("FAIL conflict_fill%0d: got flag=%0h inst=%h expected flag=1 inst=%h", i, IF_flag, IF_inst, datas[i]);
      end
      tick();
    end
  endtask

  task test_flush_miss;
    fetch(32'h0000_0010);
    exp_misses++;
    checks++; if (MC_req !== 1'b1) begin failures++; $display("FAIL flush_miss_req: got %0h expected 1", MC_req); end
    tick();
    jump_wrong_flag = 1'b1;
    tick();
    jump_wrong_flag = 1'b0;
    checks++; if (MC_req !== 1'b0 || IF_flag !== 1'b0) begin
      failures++; $display("FAIL flush_miss_drop: got req=%0h flag=%0h expected req=0 flag=0", MC_req, IF_flag);
    end
    tick();
    checks++; if (MC_req !== 1'b0 || IF_flag !== 1'b0) begin
      failures++; $display("FAIL flush_miss_idle: got req=%0h flag=%0h expected req=0 flag=0", MC_req, IF_flag);
    end
    fetch(32'h0000_0010);
    exp_misses++;
    checks++; if (MC_req !== 1'b1 || MC_addr !== 32'h10) begin
      failures++; $display("FAIL flush_miss_refetch: got req=%0h addr=%h expected req=1 addr=00000010", MC_req, MC_addr);
    end
    mc_return(32'h1010_1010, 1);
    checks++; if (IF_flag !== 1'b1 || IF_inst !== 32'h1010_1010) begin
      failures++; $display("FAIL flush_miss_fill: got flag=%0h inst=%h expected flag=1 inst=10101010", IF_flag, IF_inst);
    end
    tick();
  endtask

  task test_flush_fill;
    fetch(32'h0000_0020);
    exp_misses++;
    tick();
    tick();
    MC_flag = 1'b1; MC_inst = 32'hDEAD_BEEF; jump_wrong_flag = 1'b1;
    tick();
    MC_flag = 1'b0; jump_wrong_flag = 1'b0;
    checks++; if (IF_flag !== 1'b0 || MC_req !== 1'b0) begin
      failures++; $display("FAIL flush_fill_resp: got flag=%0h req=%0h expected flag=0 req=0", IF_flag, MC_req);
    end
    tick();
    fetch(32'h0000_0020);
    exp_hits++;
    checks++; if (IF_flag !== 1'b1 || IF_inst !== 32'hDEAD_BEEF || MC_req !== 1'b0) begin
      failures++; $display("FAIL flush_fill_hit: got flag=%0h inst=%h req=%0h expected flag=1 inst=deadbeef req=0", IF_flag, IF_inst, MC_req);
    end
    tick();
    // A hit in the flush cycle must not respond.
    IF_req = 1'b1; IF_addr = 32'h0000_0000; jump_wrong_flag = 1'b1;
    tick();
    IF_req = 1'b0; jump_wrong_flag = 1'b0;
    checks++; if (IF_flag !== 1'b0 || IF_inst !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL flush_hit: got flag=%0h inst=%h expected flag=0 inst=deadbeef", IF_flag, IF_inst);
    end
    tick();
  endtask

  task test_back_to_back;
    IF_req = 1'b1;
    IF_addr = 32'h0000_0000;
    tick();
    checks++; if (IF_flag !== 1'b1 || IF_inst !== 32'h0000_0513) begin
      failures++; $display("FAIL b2b_0: got flag=%0h inst=%h expected flag=1 inst=00000513", IF_flag, IF_inst);
    end
    IF_addr = 32'h0000_0023;
    tick();
    checks++; if (IF_flag !== 1'b1 || IF_inst !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL b2b_offset: got flag=%0h inst=%h expected flag=1 inst=deadbeef", IF_flag, IF_inst);
    end
    IF_addr = 32'h0000_0007;
    tick();
    checks++; if (IF_flag !== 1'b1 || IF_inst !== 32'h0000_1111 || MC_req !== 1'b0) begin
      failures++; $display("FAIL b2b_2: got flag=%0h inst=%h req=%0h expected flag=1 inst=00001111 req=0", IF_flag, IF_inst, MC_req);
    end
    exp_hits += 3;
    IF_req = 1'b0;
    tick();
    checks++; if (IF_flag !== 1'b0) begin failures++; $display("FAIL b2b_end: got %0h expected 0", IF_flag); end
  endtask

  task test_rdy_freeze;
    fetch(32'h0000_0030);
    exp_misses++;
    checks++; if (MC_req !== 1'b1) begin failures++; $display("FAIL rdy_miss: got %0h expected 1", MC_req); end
    rdy = 1'b0; MC_flag = 1'b1; MC_inst = 32'hBAD0_BAD0; jump_wrong_flag = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (MC_req !== 1'b1 || MC_addr !== 32'h30 || IF_flag !== 1'b0) begin
        failures++; $display("FAIL rdy_frozen%0d: got req=%0h addr=%h flag=%0h expected req=1 addr=00000030 flag=0", i, MC_req, MC_addr, IF_flag);
      end
`ifdef ICACHE_STATS_EN
      checks++; if (stat_hit !== exp_hits || stat_miss !== exp_misses) begin
        failures++; $display("FAIL rdy_stats%0d: got hit=%0d miss=%0d expected hit=%0d miss=%0d", i, stat_hit, stat_miss, exp_hits, exp_misses);
      end
`endif
    end
    MC_flag = 1'b0; jump_wrong_flag = 1'b0; rdy = 1'b1;
    tick();
    checks++; if (MC_req !== 1'b1) begin failures++; $display("FAIL rdy_resume: got %0h expected 1", MC_req); end
    mc_return(32'h3030_3030, 0);
    checks++; if (IF_flag !== 1'b1 || IF_inst !== 32'h3030_3030) begin
      failures++; $display("FAIL rdy_fill: got flag=%0h inst=%h expected flag=1 inst=30303030", IF_flag, IF_inst);
    end
    rdy = 1'b0;
    tick();
    checks++; if (IF_flag !== 1'b1) begin failures++; $display("FAIL rdy_flag_hold: got %0h expected 1", IF_flag); end
    rdy = 1'b1;
    tick();
    checks++; if (IF_flag !== 1'b0) begin failures++; $display("FAIL rdy_flag_clear: got %0h expected 0", IF_flag); end
  endtask

  task test_stats;
`ifdef ICACHE_STATS_EN
    checks++; if (stat_hit !== exp_hits) begin failures++; $display("FAIL stat_hit: got %0d expected %0d", stat_hit, exp_hits); end
    checks++; if (stat_miss !== exp_misses) begin failures++; $display("FAIL stat_miss: got %0d expected %0d", stat_miss, exp_misses); end
`endif
  endtask

  task test_reset_mid_miss;
    fetch(32'h0000_0040);
    checks++; if (MC_req !== 1'b1) begin failures++; $display("FAIL rmm_miss: got %0h expected 1", MC_req); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (MC_req !== 1'b0 || MC_addr !== 32'h0) begin
      failures++; $display("FAIL rmm_async: got req=%0h addr=%h expected req=0 addr=0", MC_req, MC_addr);
    end
    #1;
    rst = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    tick();
    fetch(32'h0000_0000);
    exp_misses++;
    checks++; if (MC_req !== 1'b1 || IF_flag !== 1'b0) begin
      failures++; $display("FAIL rmm_valid_cleared: got req=%0h flag=%0h expected req=1 flag=0", MC_req, IF_flag);
    end
    mc_return(32'h0000_0513, 1);
    tick();
    test_stats();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush_miss();
    test_flush_fill();
    test_back_to_back();
    test_rdy_freeze();
    test_stats();
    test_reset_mid_miss();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
